// File: rtl/adder_op_feeder.sv
// Self-checking front end for a WIDTH-bit adder: queues operand triples, drives them
// one per clock, and checks the returned {cout,sum} one cycle later.
module adder_op_feeder #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             start,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             cin,
   input  logic [WIDTH-1:0] sum,
   input  logic             cout,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err
);

   // state | meaning
   // IDLE  | waiting for start with a non-empty FIFO; a/b/cin hold
   // RUN   | pop one triple per cycle onto the adder, check the previous one
   // DRAIN | check the final triple, zero the adder inputs, pulse done
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam int PW = $clog2(DEPTH);
   localparam int EW = 2 * WIDTH + 1;
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   state_t           state_q;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             cin_q;
   logic [WIDTH:0]   exp_q, exp_d;
   logic             exp_vld_q;
   logic             busy_q, done_q, err_q;
   logic [CNT_W-1:0] pass_q, fail_q;

   logic             push, pop, match;
   logic [WIDTH-1:0] head_a, head_b;
   logic             head_cin;

   assign in_ready = (count_q != FULL);
   assign push     = in_valid & in_ready;
   // RUN never sees an empty FIFO: it is left as soon as the last entry is popped
   assign pop      = (state_q == RUN);

   always_comb begin
      head_a   = mem_q[rd_ptr_q][EW-1:WIDTH+1];
      head_b   = mem_q[rd_ptr_q][WIDTH:1];
      head_cin = mem_q[rd_ptr_q][0];
      exp_d    = {1'b0, head_a} + {1'b0, head_b} + {{WIDTH{1'b0}}, head_cin};
      match    = ({cout, sum} == exp_q);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_a, in_b, in_cin};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         exp_q     <= '0;
         exp_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         pass_q    <= '0;
         fail_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;

         done_q <= 1'b0;

         if (exp_vld_q) begin
            if (match) begin
               if (pass_q != '1) pass_q <= pass_q + 1'b1;
            end else begin
               if (fail_q != '1) fail_q <= fail_q + 1'b1;
               err_q <= 1'b1;
            end
         end

         case (state_q)
            IDLE: begin
               exp_vld_q <= 1'b0;
               if (start && count_q != '0) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               a_q       <= head_a;
               b_q       <= head_b;
               cin_q     <= head_cin;
               exp_q     <= exp_d;
               exp_vld_q <= 1'b1;
               if (count_q == (PW + 1)'(1) && !push) state_q <= DRAIN;
            end
            DRAIN: begin
               a_q       <= '0;
               b_q       <= '0;
               cin_q     <= 1'b0;
               exp_vld_q <= 1'b0;
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a        = a_q;
   assign b        = b_q;
   assign cin      = cin_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass_cnt = pass_q;
   assign fail_cnt = fail_q;
   assign err      = err_q;

endmodule

// File: tb/tb_adder_op_feeder.sv
// Bench for adder_op_feeder: directed vector table, multi-cycle corner sequences and a
// randomized phase checked against a queue-based scoreboard with injectable adder faults.
module tb_adder_op_feeder;
   localparam int W = 2;
   localparam int D = 4;
   localparam int C = 8;
   localparam int CMAX = (1 << C) - 1;

   logic         clk = 1'b0, rst = 1'b1;
   logic         in_valid = 1'b0, in_cin = 1'b0, start = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0;
   logic         in_ready, cin, cout, busy, done, err;
   logic [W-1:0] a, b, sum;
   logic [C-1:0] pass_cnt, fail_cnt;
   logic [2:0]   bad_mask = '0;

   always #5 clk = ~clk;

   // behavioural adder with an optional xor fault on {cout,sum}
   assign {cout, sum} = ({1'b0, a} + {1'b0, b} + {2'b00, cin}) ^ bad_mask;

   adder_op_feeder #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .start(start),
      .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
      .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err)
   );

   typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic c;} op_t;
   typedef struct {int a; int b; int c; logic [2:0] mask; int ok;} vec_t;

   op_t  q[$];
   int   total = 0, bad = 0;
   int   exp_pass = 0, exp_fail = 0;
   int   done_cnt = 0, ops_cnt = 0, busy_cycles = 0;
   int   dir_pass = 0, dir_fail = 0;
   bit   prev_busy = 1'b0, rand_mode = 1'b0;
   logic [2:0] dir_mask = '0;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   // scoreboard: every busy cycle after the first shows the next queued triple
   always @(negedge clk) begin
      op_t        e;
      logic [2:0] m;
      if (rst) begin
         q.delete();
         prev_busy = 1'b0;
         exp_pass  = 0;
         exp_fail  = 0;
         bad_mask  = '0;
      end else begin
         if (done) done_cnt++;
         if (busy) busy_cycles++;
         if (busy && prev_busy) begin
            ops_cnt++;
            if (q.size() == 0) check("op_underflow", 1, 0);
            else begin
               e = q.pop_front();
               check("drv_a", int'(a), int'(e.a));
               check("drv_b", int'(b), int'(e.b));
               check("drv_cin", int'(cin), int'(e.c));
            end
            if (rand_mode) m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            else           m = dir_mask;
            bad_mask = m;
            if (m == 3'd0) exp_pass++;
            else           exp_fail++;
         end else begin
            bad_mask = '0;
         end
         check("in_ready", int'(in_ready), int'(q.size() != D));
         prev_busy = busy;
      end
   end

   task automatic cyc(input bit v, input int ta, input int tb_, input int tc, input bit st);
      @(negedge clk); #1;
      in_valid = v;
      in_a     = ta[W-1:0];
      in_b     = tb_[W-1:0];
      in_cin   = tc[0];
      start    = st;
      if (v && in_ready) begin
         op_t o;
         o.a = ta[W-1:0];
         o.b = tb_[W-1:0];
         o.c = tc[0];
         q.push_back(o);
      end
   endtask

   task automatic wait_done(input int budget);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         cyc(0, 0, 0, 0, 0);
         n++;
      end
      check("done_pulses", done_cnt - d0, 1);
   endtask

   task automatic run_vec(input vec_t v);
      dir_mask = v.mask;
      cyc(1, v.a, v.b, v.c, 0);
      cyc(0, 0, 0, 0, 1);
      wait_done(20);
      if (v.ok != 0) dir_pass++;
      else           dir_fail++;
      check("vec_pass_cnt", int'(pass_cnt), sat(dir_pass));
      check("vec_fail_cnt", int'(fail_cnt), sat(dir_fail));
      check("vec_err", int'(err), int'(dir_fail != 0));
      check("vec_idle_a", int'(a), 0);
      check("vec_busy", int'(busy), 0);
      dir_mask = '0;
   endtask

   vec_t tbl[6];

   initial begin
      int d0, o0, b0, n;
      tbl[0] = '{1, 2, 0, 3'b000, 1};
      tbl[1] = '{3, 1, 1, 3'b000, 1};
      tbl[2] = '{3, 1, 1, 3'b001, 0};
      tbl[3] = '{2, 2, 0, 3'b000, 1};
      tbl[4] = '{3, 3, 1, 3'b100, 0};
      tbl[5] = '{0, 0, 0, 3'b000, 1};

      // reset state
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      check("rst_a", int'(a), 0);
      check("rst_b", int'(b), 0);
      check("rst_cin", int'(cin), 0);
      check("rst_ready", int'(in_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_pass", int'(pass_cnt), 0);
      check("rst_fail", int'(fail_cnt), 0);
      check("rst_err", int'(err), 0);

      // start while empty is ignored
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      check("empty_start_busy", int'(busy), 0);

      foreach (tbl[i]) run_vec(tbl[i]);

      // full FIFO, dropped fifth offer, four back-to-back checks
      d0 = done_cnt; o0 = ops_cnt; b0 = busy_cycles;
      for (int i = 0; i < 5; i++) cyc(1, i, 3 - i, i & 1, 0);
      check("full_ready", int'(in_ready), 0);
      cyc(0, 0, 0, 0, 1);
      wait_done(30);
      dir_pass += 4;
      check("full_ops", ops_cnt - o0, 4);
      check("full_busy_cycles", busy_cycles - b0, 5);
      check("full_done", done_cnt - d0, 1);
      check("full_pass", int'(pass_cnt), sat(dir_pass));

      // continuous pushes during RUN keep it from draining; pointers wrap
      d0 = done_cnt; o0 = ops_cnt;
      cyc(1, 1, 1, 0, 0);
      cyc(1, 2, 1, 1, 1);
      for (int i = 0; i < 5; i++) cyc(1, i, i + 1, i & 1, 0);
      cyc(0, 0, 0, 0, 0);
      check("stream_no_early_done", done_cnt - d0, 0);
      check("stream_busy", int'(busy), 1);
      wait_done(40);
      dir_pass += 7;
      check("stream_ops", ops_cnt - o0, 7);
      check("stream_pass", int'(pass_cnt), sat(dir_pass));

      // reset in the middle of a run
      o0 = ops_cnt;
      for (int i = 0; i < 4; i++) cyc(1, 3, i, 1, 0);
      cyc(0, 0, 0, 0, 1);
      n = 0;
      while (ops_cnt - o0 < 2 && n < 20) begin
         cyc(0, 0, 0, 0, 0);
         n++;
      end
      check("midrun_reached", int'(ops_cnt - o0 >= 2), 1);
      @(negedge clk); #1 rst = 1'b1;
      @(negedge clk); #1 rst = 1'b0;
      dir_pass = 0; dir_fail = 0;
      check("mr_pass", int'(pass_cnt), 0);
      check("mr_fail", int'(fail_cnt), 0);
      check("mr_err", int'(err), 0);
      check("mr_busy", int'(busy), 0);
      check("mr_ready", int'(in_ready), 1);
      check("mr_a", int'(a), 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      check("mr_no_stale_pass", int'(pass_cnt), 0);
      check("mr_no_stale_fail", int'(fail_cnt), 0);
      check("mr_idle_busy", int'(busy), 0);
      run_vec(tbl[0]);

      // randomized traffic with random adder faults; pass_cnt saturates
      rand_mode = 1'b1;
      for (int i = 0; i < 1200; i++)
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 4) == 0);
      n = 0;
      while ((q.size() != 0 || busy) && n < 300) begin
         cyc(0, 0, 0, 0, !busy);
         n++;
      end
      check("rand_drained", int'(n < 300), 1);
      repeat (2) cyc(0, 0, 0, 0, 0);
      check("rand_pass", int'(pass_cnt), sat(exp_pass));
      check("rand_fail", int'(fail_cnt), sat(exp_fail));
      check("rand_err", int'(err), int'(exp_fail != 0));
      check("rand_q_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
